// File: rtl/iomem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : iomem_bus_ctrl
// Brief    : Single-master to four-slot memory-mapped bus bridge. Decodes
//            addr[31:24] into a one-hot slot select, waits for the selected
//            slot to complete (with a cycle timeout), and returns a
//            one-cycle registered completion pulse. Decode misses and
//            timeouts are reported via err_pulse/err_addr/err_count.
// Revision : 1.0 - initial release
// ============================================================================
module iomem_bus_ctrl #(
    parameter logic [7:0] BASE_ID        = 8'h03,
    parameter int         TIMEOUT_CYCLES = 255
) (
    input  logic         CLK,
    input  logic         resetn,
    input  logic         m_valid,
    input  logic [31:0]  m_addr,
    input  logic [31:0]  m_wdata,
    input  logic [3:0]   m_wstrb,
    output logic         m_ready,
    output logic [31:0]  m_rdata,
    output logic [3:0]   s_valid,
    output logic [31:0]  s_addr,
    output logic [31:0]  s_wdata,
    output logic [3:0]   s_wstrb,
    input  logic [3:0]   s_ready,
    input  logic [127:0] s_rdata,
    output logic         err_pulse,
    output logic [31:0]  err_addr,
    output logic [7:0]   err_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    // Last counter value at which the slot may still answer before the
    // transfer is forced to an error response.
    localparam logic [7:0] c_to_last = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_slot;
    logic [7:0]  r_cnt;
    logic        r_err_pend;

    logic [7:0]  w_slot_raw;
    logic        w_hit;
    logic        w_accept;
    logic        w_ready_hit;
    logic        w_timeout;

    // Address decode and transfer-event qualification.
    always_comb begin
        w_slot_raw  = m_addr[31:24] - BASE_ID;
        // The >= test rejects values that only land in range because
        // BASE_ID+3 wrapped past 8'hFF.
        w_hit       = (w_slot_raw < 8'd4) && (m_addr[31:24] >= BASE_ID);
        // A request is never taken while the previous completion pulse is out.
        w_accept    = (r_state == S_IDLE) && m_valid && !m_ready;
        w_ready_hit = (r_state == S_ACTIVE) && s_ready[r_slot];
        // Ready wins a tie with the timeout.
        w_timeout   = (r_state == S_ACTIVE) && !s_ready[r_slot] && (r_cnt == c_to_last);
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_hit ? S_ACTIVE : S_RESP;
                end
            end
            S_ACTIVE: begin
                if (w_ready_hit || w_timeout) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath: request latch, slot select, response capture and error tracking.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            m_ready    <= 1'b0;
            m_rdata    <= 32'h0;
            s_valid    <= 4'b0000;
            s_addr     <= 32'h0;
            s_wdata    <= 32'h0;
            s_wstrb    <= 4'h0;
            err_pulse  <= 1'b0;
            err_addr   <= 32'h0;
            err_count  <= 8'h00;
            r_slot     <= 2'd0;
            r_cnt      <= 8'h00;
            r_err_pend <= 1'b0;
        end else begin
            // The completion pulse (and any error pulse) is issued on the
            // edge that leaves RESP, so both are coincident and last one cycle.
            m_ready   <= (r_state == S_RESP);
            err_pulse <= (r_state == S_RESP) && r_err_pend;
            if ((r_state == S_RESP) && r_err_pend && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end

            if (w_accept) begin
                s_addr  <= m_addr;
                s_wdata <= m_wdata;
                s_wstrb <= m_wstrb;
                r_cnt   <= 8'h00;
                if (w_hit) begin
                    s_valid    <= 4'b0001 << w_slot_raw[1:0];
                    r_slot     <= w_slot_raw[1:0];
                    r_err_pend <= 1'b0;
                end else begin
                    m_rdata    <= 32'h0;
                    err_addr   <= m_addr;
                    r_err_pend <= 1'b1;
                end
            end

            if (w_ready_hit) begin
                m_rdata    <= s_rdata[{r_slot, 5'd0} +: 32];
                s_valid    <= 4'b0000;
                r_err_pend <= 1'b0;
            end else if (w_timeout) begin
                m_rdata    <= 32'hFFFF_FFFF;
                s_valid    <= 4'b0000;
                err_addr   <= s_addr;
                r_err_pend <= 1'b1;
            end else if (r_state == S_ACTIVE) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iomem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_iomem_bus_ctrl
// Brief    : Directed self-checking bench for iomem_bus_ctrl (BASE_ID=8'h03,
//            TIMEOUT_CYCLES=8). Inputs change and outputs are sampled on the
//            falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iomem_bus_ctrl;

    logic         CLK;
    logic         resetn;
    logic         m_valid;
    logic [31:0]  m_addr;
    logic [31:0]  m_wdata;
    logic [3:0]   m_wstrb;
    logic         m_ready;
    logic [31:0]  m_rdata;
    logic [3:0]   s_valid;
    logic [31:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [3:0]   s_wstrb;
    logic [3:0]   s_ready;
    logic [127:0] s_rdata;
    logic         err_pulse;
    logic [31:0]  err_addr;
    logic [7:0]   err_count;

    int n_checks = 0;
    int n_pass   = 0;

    iomem_bus_ctrl #(
        .BASE_ID        (8'h03),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .CLK       (CLK),
        .resetn    (resetn),
        .m_valid   (m_valid),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_ready   (m_ready),
        .m_rdata   (m_rdata),
        .s_valid   (s_valid),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_ready   (s_ready),
        .s_rdata   (s_rdata),
        .err_pulse (err_pulse),
        .err_addr  (err_addr),
        .err_count (err_count)
    );

    // Free-running clock, 10 time-unit period.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Present one request for exactly one rising edge; returns on the falling
    // edge after the acceptance edge.
    task automatic drive_req(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb);
        m_valid = 1'b1;
        m_addr  = addr;
        m_wdata = wdata;
        m_wstrb = wstrb;
        @(negedge CLK);
        m_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn  = 1'b0;
        m_valid = 1'b1;
        m_addr  = 32'h0300_0000;
        m_wdata = 32'hA5A5_A5A5;
        m_wstrb = 4'h3;
        s_ready = 4'b0000;
        s_rdata = '0;
        repeat (3) @(negedge CLK);
        n_checks++; if (m_ready !== 1'b0)    $display("FAIL rst_m_ready got %h want 0", m_ready);     else n_pass++;
        n_checks++; if (s_valid !== 4'b0000) $display("FAIL rst_s_valid got %h want 0", s_valid);     else n_pass++;
        n_checks++; if (err_pulse !== 1'b0)  $display("FAIL rst_err_pulse got %h want 0", err_pulse); else n_pass++;
        n_checks++; if (err_count !== 8'h00) $display("FAIL rst_err_count got %h want 0", err_count); else n_pass++;
        n_checks++; if (err_addr !== 32'h0)  $display("FAIL rst_err_addr got %h want 0", err_addr);   else n_pass++;
        n_checks++; if (m_rdata !== 32'h0)   $display("FAIL rst_m_rdata got %h want 0", m_rdata);     else n_pass++;
        n_checks++; if ({s_addr, s_wdata, s_wstrb} !== 68'h0)
            $display("FAIL rst_s_bus got %h/%h/%h want 0", s_addr, s_wdata, s_wstrb); else n_pass++;
        // Request held across reset release is taken on the first live edge.
        resetn = 1'b1;
        @(negedge CLK);
        m_valid = 1'b0;
        n_checks++; if (s_valid !== 4'b0001) $display("FAIL rst_first_accept got %h want 1", s_valid); else n_pass++;
        n_checks++; if (s_addr !== 32'h0300_0000 || s_wstrb !== 4'h3)
            $display("FAIL rst_first_latch got %h/%h want 03000000/3", s_addr, s_wstrb); else n_pass++;
        s_ready = 4'b0001;
        s_rdata[31:0] = 32'h1111_2222;
        @(negedge CLK);
        s_ready = 4'b0000;
        @(negedge CLK);
        n_checks++; if (m_ready !== 1'b1 || m_rdata !== 32'h1111_2222)
            $display("FAIL rst_first_resp got %h/%h want 1/11112222", m_ready, m_rdata); else n_pass++;
        @(negedge CLK);
    endtask

    task automatic test_write_hit();
        drive_req(32'h0400_0000, 32'h1234_5678, 4'hF);
        n_checks++; if (s_valid !== 4'b0010) $display("FAIL wr_s_valid got %h want 2", s_valid); else n_pass++;
        n_checks++; if (s_wdata !== 32'h1234_5678 || s_wstrb !== 4'hF || s_addr !== 32'h0400_0000)
            $display("FAIL wr_latch got %h/%h/%h want 04000000/12345678/f", s_addr, s_wdata, s_wstrb); else n_pass++;
        repeat (2) @(negedge CLK);
        n_checks++; if (m_ready !== 1'b0 || s_valid !== 4'b0010)
            $display("FAIL wr_wait got %h/%h want 0/2", m_ready, s_valid); else n_pass++;
        s_ready = 4'b0010;
        @(negedge CLK);
        s_ready = 4'b0000;
        n_checks++; if (s_valid !== 4'b0000 || m_ready !== 1'b0 || s_wdata !== 32'h1234_5678)
            $display("FAIL wr_resp_state got %h/%h/%h want 0/0/12345678", s_valid, m_ready, s_wdata); else n_pass++;
        @(negedge CLK);
        n_checks++; if (m_ready !== 1'b1 || err_pulse !== 1'b0 || err_count !== 8'h00)
            $display("FAIL wr_done got %h/%h/%h want 1/0/00", m_ready, err_pulse, err_count); else n_pass++;
        @(negedge CLK);
        n_checks++; if (m_ready !== 1'b0) $display("FAIL wr_pulse_width got %h want 0", m_ready); else n_pass++;
    endtask

    task automatic test_read_hit();
        s_rdata[127:96] = 32'hCAFE_F00D;
        drive_req(32'h0600_0010, 32'h0, 4'h0);
        n_checks++; if (s_valid !== 4'b1000 || s_wstrb !== 4'h0)
            $display("FAIL rd_select got %h/%h want 8/0", s_valid, s_wstrb); else n_pass++;
        s_ready = 4'b1000;
        @(negedge CLK);
        s_ready = 4'b0000;
        n_checks++; if (m_ready !== 1'b0) $display("FAIL rd_early got %h want 0", m_ready); else n_pass++;
        @(negedge CLK);
        n_checks++; if (m_ready !== 1'b1 || m_rdata !== 32'hCAFE_F00D)
            $display("FAIL rd_data got %h/%h want 1/cafef00d", m_ready, m_rdata); else n_pass++;
        @(negedge CLK);
    endtask

    task automatic test_decode_miss();
        logic [31:0] addrs [3];
        addrs[0] = 32'h0900_0000;
        addrs[1] = 32'h0700_0000;  // one past the last slot
        addrs[2] = 32'h02FF_FFFF;  // one below slot 0
        for (int i = 0; i < 3; i++) begin
            drive_req(addrs[i], 32'hFFFF_0000, 4'h1);
            n_checks++; if (s_valid !== 4'b0000 || m_ready !== 1'b0)
                $display("FAIL miss%0d_no_select got %h/%h want 0/0", i, s_valid, m_ready); else n_pass++;
            @(negedge CLK);
            n_checks++; if (m_ready !== 1'b1 || err_pulse !== 1'b1 || m_rdata !== 32'h0 || err_addr !== addrs[i])
                $display("FAIL miss%0d_resp got %h/%h/%h/%h want 1/1/0/%h",
                         i, m_ready, err_pulse, m_rdata, err_addr, addrs[i]); else n_pass++;
            n_checks++; if (err_count !== 8'(i + 1))
                $display("FAIL miss%0d_count got %h want %h", i, err_count, 8'(i + 1)); else n_pass++;
            @(negedge CLK);
            n_checks++; if (m_ready !== 1'b0 || err_pulse !== 1'b0)
                $display("FAIL miss%0d_pulse_width got %h/%h want 0/0", i, m_ready, err_pulse); else n_pass++;
        end
    endtask

    task automatic test_timeout();
        s_rdata[95:64] = 32'hDEAD_BEEF;
        s_ready = 4'b0100;  // stray ready from a slot that is not selected
        drive_req(32'h0300_0100, 32'h0, 4'hF);
        repeat (7) @(negedge CLK);
        n_checks++; if (s_valid !== 4'b0001 || m_ready !== 1'b0)
            $display("FAIL to_still_active got %h/%h want 1/0", s_valid, m_ready); else n_pass++;
        @(negedge CLK);
        n_checks++; if (s_valid !== 4'b0000 || m_ready !== 1'b0)
            $display("FAIL to_drop got %h/%h want 0/0", s_valid, m_ready); else n_pass++;
        @(negedge CLK);
        s_ready = 4'b0000;
        n_checks++; if (m_ready !== 1'b1 || m_rdata !== 32'hFFFF_FFFF || err_pulse !== 1'b1)
            $display("FAIL to_resp got %h/%h/%h want 1/ffffffff/1", m_ready, m_rdata, err_pulse); else n_pass++;
        n_checks++; if (err_addr !== 32'h0300_0100 || err_count !== 8'h04)
            $display("FAIL to_err got %h/%h want 03000100/04", err_addr, err_count); else n_pass++;
        @(negedge CLK);
    endtask

    task automatic test_tie();
        s_rdata[95:64] = 32'h5555_AAAA;
        drive_req(32'h0500_0000, 32'h0, 4'h0);
        repeat (7) @(negedge CLK);
        s_ready = 4'b0100;  // arrives exactly on the timeout cycle
        @(negedge CLK);
        s_ready = 4'b0000;
        n_checks++; if (s_valid !== 4'b0000 || m_ready !== 1'b0)
            $display("FAIL tie_drop got %h/%h want 0/0", s_valid, m_ready); else n_pass++;
        @(negedge CLK);
        n_checks++; if (m_ready !== 1'b1 || err_pulse !== 1'b0 || m_rdata !== 32'h5555_AAAA || err_count !== 8'h04)
            $display("FAIL tie_resp got %h/%h/%h/%h want 1/0/5555aaaa/04",
                     m_ready, err_pulse, m_rdata, err_count); else n_pass++;
        @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        logic seen;
        drive_req(32'h0400_0000, 32'h0, 4'hF);
        n_checks++; if (s_valid !== 4'b0010) $display("FAIL rm_active got %h want 2", s_valid); else n_pass++;
        resetn = 1'b0;
        @(negedge CLK);
        resetn = 1'b1;
        n_checks++; if (s_valid !== 4'b0000 || err_count !== 8'h00 || m_ready !== 1'b0)
            $display("FAIL rm_cleared got %h/%h/%h want 0/00/0", s_valid, err_count, m_ready); else n_pass++;
        s_ready = 4'b0010;  // must be ignored in IDLE
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            seen = seen | m_ready;
        end
        s_ready = 4'b0000;
        n_checks++; if (seen !== 1'b0) $display("FAIL rm_no_pulse got %h want 0", seen); else n_pass++;
        s_rdata[63:32] = 32'h7777_8888;
        drive_req(32'h0400_0004, 32'h0, 4'h0);
        s_ready = 4'b0010;
        @(negedge CLK);
        s_ready = 4'b0000;
        @(negedge CLK);
        n_checks++; if (m_ready !== 1'b1 || m_rdata !== 32'h7777_8888)
            $display("FAIL rm_fresh got %h/%h want 1/77778888", m_ready, m_rdata); else n_pass++;
        @(negedge CLK);
    endtask

    task automatic test_back_to_back();
        logic [5:0] pat;
        m_valid = 1'b1;
        m_addr  = 32'h0A00_0000;
        m_wstrb = 4'h0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            pat[i] = m_ready;
        end
        m_valid = 1'b0;
        repeat (2) @(negedge CLK);
        n_checks++; if (pat !== 6'b010010)
            $display("FAIL b2b_pattern got %b want 010010", pat); else n_pass++;
        n_checks++; if (err_count !== 8'h02)
            $display("FAIL b2b_count got %h want 02", err_count); else n_pass++;
    endtask

    task automatic test_err_saturate();
        m_valid = 1'b1;
        m_addr  = 32'h0B00_0000;
        repeat (260 * 3) @(negedge CLK);
        m_valid = 1'b0;
        repeat (3) @(negedge CLK);
        n_checks++; if (err_count !== 8'hFF)
            $display("FAIL sat_count got %h want ff", err_count); else n_pass++;
        n_checks++; if (err_addr !== 32'h0B00_0000)
            $display("FAIL sat_addr got %h want 0b000000", err_addr); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_hit();
        test_read_hit();
        test_decode_miss();
        test_timeout();
        test_tie();
        test_reset_mid();
        test_back_to_back();
        test_err_saturate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
